// File: rtl/dc_motor_pwm_decoder_if.sv
// PWM line from the motor-side source plus the speed telemetry returned by the decoder.
interface dc_motor_pwm_decoder_if;
   logic        pwm_in;
   logic [2:0]  duty_code;
   logic [12:0] high_ticks;
   logic [12:0] period_tks;
   logic        upd;
   logic        locked;
   logic        err;

   modport master (
      output pwm_in,
      input  duty_code, high_ticks, period_tks, upd, locked, err
   );

   modport slave (
      input  pwm_in,
      output duty_code, high_ticks, period_tks, upd, locked, err
   );
endinterface

// File: rtl/dc_motor_pwm_decoder.sv
// Measures PWM high time and period in prescaled ticks and recovers the 3-bit speed code.
// Define PWM_FILTER_EN to require 3 agreeing tick samples before the sampled line level changes.
module dc_motor_pwm_decoder #(
   parameter int DIV_W      = 8,
   parameter int PERIOD_NOM = 4096,
   parameter int PERIOD_TOL = 64,
   parameter int MIN_HIGH   = 100,
   parameter int MAX_HIGH   = 2650,
   parameter int TIMEOUT    = 6144
) (
   input  logic                  clk,
   input  logic                  rst,
   dc_motor_pwm_decoder_if.slave bus
);
   localparam int            PW        = (DIV_W > 0) ? DIV_W : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'((1 << DIV_W) - 1);
   localparam logic [12:0]   CNT_TO    = 13'(TIMEOUT);
   localparam logic [12:0]   PER_LO    = 13'(PERIOD_NOM - PERIOD_TOL);
   localparam logic [12:0]   PER_HI    = 13'(PERIOD_NOM + PERIOD_TOL);
   localparam logic [12:0]   HI_MIN    = 13'(MIN_HIGH);
   localparam logic [12:0]   HI_MAX    = 13'(MAX_HIGH);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q;
   logic          tick;
   logic [1:0]    sync_q;
   logic          s_q, s_d;
   logic          rise, fall, accept;
   logic [12:0]   cnt_q, cnt_d;
   logic [12:0]   hi_q, hi_d;
   logic [12:0]   high_q, high_d;
   logic [12:0]   period_q, period_d;
   logic [2:0]    code_q, code_d;
   logic          upd_q, upd_d;
   logic          locked_q, locked_d;
   logic          err_q, err_d;

   // Nearest nominal width; a width equal to a boundary belongs to the higher code.
   function automatic logic [2:0] decode(input logic [12:0] h);
      if      (h < 13'd522)  return 3'd0;
      else if (h < 13'd950)  return 3'd1;
      else if (h < 13'd1250) return 3'd2;
      else if (h < 13'd1550) return 3'd3;
      else if (h < 13'd1850) return 3'd4;
      else if (h < 13'd2150) return 3'd5;
      else if (h < 13'd2400) return 3'd6;
      else                   return 3'd7;
   endfunction

   assign tick = (presc_q == PRESC_MAX);

`ifdef PWM_FILTER_EN
   logic [1:0] hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       hist_q <= '0;
      else if (tick) hist_q <= {hist_q[0], sync_q[1]};
   end

   assign s_d = (sync_q[1] == hist_q[0] && sync_q[1] == hist_q[1]) ? sync_q[1] : s_q;
`else
   assign s_d = sync_q[1];
`endif

   assign rise   = tick & ~s_q & s_d;
   assign fall   = tick & s_q & ~s_d;
   assign accept = (cnt_q >= PER_LO) && (cnt_q <= PER_HI) && (hi_q >= HI_MIN) && (hi_q <= HI_MAX);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      cnt_d = cnt_q;
      if (rise)                         cnt_d = 13'd1;
      else if (tick && cnt_q < CNT_TO)  cnt_d = cnt_q + 13'd1;
   end

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      high_d   = high_q;
      period_d = period_q;
      code_d   = code_q;
      upd_d    = 1'b0;
      locked_d = locked_q;
      err_d    = err_q;
      if (rise) begin
         state_d = HIGH;
         if (state_q == LOW) begin
            upd_d    = 1'b1;
            period_d = cnt_q;
            high_d   = hi_q;
            if (accept) begin
               code_d   = decode(hi_q);
               locked_d = 1'b1;
               err_d    = 1'b0;
            end else begin
               locked_d = 1'b0;
               err_d    = 1'b1;
            end
         end
      end else if (fall && state_q == HIGH) begin
         state_d = LOW;
         hi_d    = cnt_q;
      end else if (tick && cnt_q == CNT_TO) begin
         // Line stuck in either level: drop lock and wait for a fresh rise to re-arm.
         state_d  = IDLE;
         locked_d = 1'b0;
         err_d    = 1'b1;
      end
   end

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         sync_q   <= '0;
         s_q      <= 1'b0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         hi_q     <= '0;
         high_q   <= '0;
         period_q <= '0;
         code_q   <= '0;
         upd_q    <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         presc_q  <= tick ? '0 : presc_q + PW'(1);
         sync_q   <= {sync_q[0], bus.pwm_in};
         if (tick) s_q <= s_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         hi_q     <= hi_d;
         high_q   <= high_d;
         period_q <= period_d;
         code_q   <= code_d;
         upd_q    <= upd_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign bus.duty_code  = code_q;
   assign bus.high_ticks = high_q;
   assign bus.period_tks = period_q;
   assign bus.upd        = upd_q;
   assign bus.locked     = locked_q;
   assign bus.err        = err_q;
endmodule
